rvx_core_fetch_unit: RTL and testbench



---
 rtl/rvx_core_fetch_unit.sv | 118 +++++++++++
 tb/tb_rvx_core_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_core_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory port, tracks in-flight requests by PC
// tag, and hands up to two buffered instructions to decode, flushing on redirect.
module rvx_core_fetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_address,
  output logic        imem_request,
  input  logic        imem_grant,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect_request,
  input  logic [31:0] redirect_address,
  input  logic        stall_s1,
  output logic [31:0] instruction_s1,
  output logic [31:0] pc_s1,
  output logic        instruction_valid_s1
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q, discard_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [31:0] tag_q [2];
  logic        tag_rd_q, tag_wr_q;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_instr_q [2];
  logic        fifo_rd_q, fifo_wr_q;
  logic [31:0] last_pc_q;

  logic [2:0] credit_used;
  logic       accept, resp, drop, push, pop;

  assign credit_used  = 3'(outstanding_q) + 3'(fifo_cnt_q) + 3'(discard_q);
  assign imem_request = reset_n & ~redirect_request & (credit_used < 3'd2);
  assign imem_address = fetch_pc_q;

  assign accept = imem_request & imem_grant;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp   = imem_rvalid & (outstanding_q != 2'd0);
  assign drop   = resp & (discard_q != 2'd0);
  assign push   = resp & ~drop & ~redirect_request;
  assign pop    = instruction_valid_s1 & ~stall_s1 & ~redirect_request;

  assign instruction_valid_s1 = (fifo_cnt_q != 2'd0);
  assign instruction_s1       = instruction_valid_s1 ? fifo_instr_q[fifo_rd_q] : Nop;
  assign pc_s1                = instruction_valid_s1 ? fifo_pc_q[fifo_rd_q] : last_pc_q;

  always_comb begin
    outstanding_d = outstanding_q + 2'(accept) - 2'(resp);
    fetch_pc_d    = fetch_pc_q;
    fifo_cnt_d    = fifo_cnt_q;
    discard_d     = discard_q;
    if (redirect_request) begin
      fetch_pc_d = redirect_address & 32'hFFFF_FFFC;
      fifo_cnt_d = 2'd0;
      // Every request still in flight after this cycle belongs to the old path.
      discard_d  = outstanding_d;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
      discard_d  = discard_q - 2'(drop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= BOOT_ADDRESS;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      fifo_cnt_q    <= 2'd0;
      tag_rd_q      <= 1'b0;
      tag_wr_q      <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_wr_q     <= 1'b0;
      last_pc_q     <= BOOT_ADDRESS;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_cnt_q    <= fifo_cnt_d;
      tag_rd_q      <= tag_rd_q ^ resp;
      tag_wr_q      <= tag_wr_q ^ accept;
      last_pc_q     <= pc_s1;
      if (redirect_request) begin
        fifo_rd_q <= 1'b0;
        fifo_wr_q <= 1'b0;
      end else begin
        fifo_rd_q <= fifo_rd_q ^ pop;
        fifo_wr_q <= fifo_wr_q ^ push;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        tag_q[i]        <= '0;
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      if (accept) tag_q[tag_wr_q] <= fetch_pc_q;
      if (push) begin
        fifo_pc_q[fifo_wr_q]    <= tag_q[tag_rd_q];
        fifo_instr_q[fifo_wr_q] <= imem_rdata;
      end
    end
  end

  rvalid_needs_outstanding: assert property (
    @(posedge clock) disable iff (!reset_n) imem_rvalid |-> (outstanding_q != 2'd0)
  );

endmodule

// File: tb/tb_rvx_core_fetch_unit.sv
// Randomized bench for rvx_core_fetch_unit against a queue-based transaction model.
module tb_rvx_core_fetch_unit;

  localparam logic [31:0] Boot = 32'h0000_0000;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem_address;
  logic        imem_request;
  logic        imem_grant = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic        redirect_request = 1'b0;
  logic [31:0] redirect_address = '0;
  logic        stall_s1 = 1'b0;
  logic [31:0] instruction_s1;
  logic [31:0] pc_s1;
  logic        instruction_valid_s1;

  rvx_core_fetch_unit #(.BOOT_ADDRESS(Boot)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .imem_address         (imem_address),
    .imem_request         (imem_request),
    .imem_grant           (imem_grant),
    .imem_rdata           (imem_rdata),
    .imem_rvalid          (imem_rvalid),
    .redirect_request     (redirect_request),
    .redirect_address     (redirect_address),
    .stall_s1             (stall_s1),
    .instruction_s1       (instruction_s1),
    .pc_s1                (pc_s1),
    .instruction_valid_s1 (instruction_valid_s1)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [31:0] pc; logic stale; } inflight_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] addr; int due; } rsp_t;

  // Reference model state
  logic [31:0] m_pc, m_last_pc;
  inflight_t   m_inflight[$];
  entry_t      m_fifo[$];
  // Memory model state
  rsp_t        rsp_q[$];
  int          cyc, last_due, gnt_wait;
  int          g_max, rd_min, rd_max;
  // Observations from the latest step
  logic        obs_valid, obs_req;
  logic [31:0] obs_pc, obs_addr;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (m_inflight[i]) if (m_inflight[i].stale) n++;
    return n;
  endfunction

  task automatic model_clear();
    m_pc = Boot;
    m_last_pc = Boot;
    m_inflight.delete();
    m_fifo.delete();
    rsp_q.delete();
    last_due = cyc;
    gnt_wait = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    imem_grant = 1'b0;
    imem_rvalid = 1'b0;
    redirect_request = 1'b0;
    stall_s1 = 1'b0;
    #1;
    check("rst_req", 32'(imem_request), 32'd0);
    check("rst_valid", 32'(instruction_valid_s1), 32'd0);
    check("rst_instr", instruction_s1, Nop);
    check("rst_pc", pc_s1, Boot);
    check("rst_addr", imem_address, Boot);
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic step(input logic redir, input logic [31:0] raddr, input logic stl);
    logic        rv, exp_req, gnt, exp_valid;
    logic [31:0] word;
    inflight_t   e;
    int          d, due;
    @(negedge clock);
    exp_valid = (m_fifo.size() != 0);
    check("valid", 32'(instruction_valid_s1), 32'(exp_valid));
    check("instr", instruction_s1, exp_valid ? m_fifo[0].instr : Nop);
    check("pc", pc_s1, exp_valid ? m_fifo[0].pc : m_last_pc);
    obs_valid = instruction_valid_s1;
    obs_pc = pc_s1;
    redirect_request = redir;
    redirect_address = raddr;
    stall_s1 = stl;
    rv = (rsp_q.size() != 0) && (rsp_q[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata = rv ? mem_word(rsp_q[0].addr) : $urandom();
    imem_grant = 1'b0;
    #1;
    exp_req = !redir && (m_inflight.size() + m_fifo.size() + stale_cnt() < 2);
    check("req", 32'(imem_request), 32'(exp_req));
    check("addr", imem_address, m_pc);
    obs_req = imem_request;
    obs_addr = imem_address;
    gnt = imem_request && (gnt_wait == 0);
    if (imem_request && gnt_wait != 0) gnt_wait--;
    imem_grant = gnt;
    if (gnt) begin
      d = $urandom_range(rd_max, rd_min);
      due = (cyc + d > last_due + 1) ? cyc + d : last_due + 1;
      rsp_q.push_back('{addr: imem_address, due: due});
      last_due = due;
      gnt_wait = $urandom_range(g_max, 0);
    end
    // Model update for the coming edge
    if (m_fifo.size() != 0) begin
      m_last_pc = m_fifo[0].pc;
      if (!stl && !redir) m_fifo.delete(0);
    end
    if (rv) begin
      word = imem_rdata;
      rsp_q.delete(0);
      if (m_inflight.size() != 0) begin
        e = m_inflight.pop_front();
        if (!e.stale && !redir) m_fifo.push_back('{pc: e.pc, instr: word});
      end
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
      m_pc = raddr & 32'hFFFF_FFFC;
    end else if (exp_req && gnt) begin
      m_inflight.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    logic found;
    int   first_valid;
    cyc = 0;
    g_max = 0; rd_min = 1; rd_max = 1;
    model_clear();

    // Single-cycle memory from reset
    do_reset();
    first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (first_valid < 0 && obs_valid) first_valid = i;
    end
    check("first_valid_cycle", 32'(first_valid), 32'd2);

    // Stall held in steady state
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    check("stall_req_low", 32'(obs_req), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);

    // Redirect with two outstanding
    rd_min = 3; rd_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_inflight.size() == 2) begin
        step(1'b1, 32'h0000_0100, 1'b0);
        found = 1'b1;
      end else step(1'b0, 32'h0, 1'b0);
    end
    check("two_outstanding_reached", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (obs_valid) found = 1'b1;
    end
    check("redir_first_valid", 32'(found), 32'd1);
    check("redir_first_pc", obs_pc, 32'h0000_0100);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);

    // Redirect in the same cycle as the only response
    rd_min = 1; rd_max = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_inflight.size() == 1 && rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
        step(1'b1, 32'h0000_0300, 1'b0);
        found = 1'b1;
      end else step(1'b0, 32'h0, 1'b0);
    end
    check("rvalid_redirect_reached", 32'(found), 32'd1);
    step(1'b0, 32'h0, 1'b0);
    check("resume_req", 32'(obs_req), 32'd1);
    check("resume_addr", obs_addr, 32'h0000_0300);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (obs_valid) found = 1'b1;
    end
    check("resume_first_pc", obs_pc, 32'h0000_0300);

    // Unaligned redirect target and wrap at the top of the address space
    step(1'b1, 32'h0000_0203, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("addr_mask", obs_addr, 32'h0000_0200);
    step(1'b1, 32'hFFFF_FFF8, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0);

    // Randomized traffic, with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        g_max = $urandom_range(3, 0);
        rd_min = $urandom_range(2, 1);
        rd_max = $urandom_range(3, rd_min);
      end
      if (i == 1500) do_reset();
      step($urandom_range(15, 0) == 0, $urandom(), $urandom_range(3, 0) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
